// File: rtl/image_row_packer.sv
// Packs a raster binary pixel stream into OUT_DIM-bit rows (SCALE x SCALE OR-reduction)
// and writes each row to the net's image registers over Avalon-MM.
module image_row_packer #(
  parameter int SCALE   = 8,
  parameter int OUT_DIM = 28
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FRAME_START,
  input  logic        PIX_VALID,
  input  logic        PIX_DATA,
  output logic        PIX_READY,
  output logic        AVL_CS,
  output logic        AVL_WRITE,
  output logic [4:0]  AVL_ADDR,
  output logic [31:0] AVL_WRITEDATA,
  output logic        BUSY,
  output logic        FRAME_DONE
);

  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int COL_W = $clog2(OUT_DIM);

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

  state_t             state, state_next;
  logic [SUB_W-1:0]   sub_col, sub_line;
  logic [COL_W-1:0]   blk_col, row_idx, bit_idx;
  logic [OUT_DIM-1:0] row_acc;
  logic               accept, sub_col_last, blk_col_last, sub_line_last, row_last, row_done;

  assign accept        = (state == ACCUM) && PIX_VALID;
  assign sub_col_last  = (sub_col == SUB_W'(SCALE - 1));
  assign blk_col_last  = (blk_col == COL_W'(OUT_DIM - 1));
  assign sub_line_last = (sub_line == SUB_W'(SCALE - 1));
  assign row_last      = (row_idx == COL_W'(OUT_DIM - 1));
  assign row_done      = accept && sub_col_last && blk_col_last && sub_line_last;
  // Output column 0 lands in the MSB of the row word.
  assign bit_idx       = COL_W'(OUT_DIM - 1) - blk_col;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb target gets a default first so no path can leave it unassigned (latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (FRAME_START) state_next = ACCUM;
      ACCUM:   if (row_done)    state_next = WRITE;
      WRITE:   state_next = row_last ? DONE : ACCUM;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: row_acc is plain flops, not a RAM, so clearing it in reset costs nothing special.
      sub_col  <= '0;
      blk_col  <= '0;
      sub_line <= '0;
      row_idx  <= '0;
      row_acc  <= '0;
    end else begin
      unique case (state)
        IDLE: if (FRAME_START) begin
          sub_col  <= '0;
          blk_col  <= '0;
          sub_line <= '0;
          row_idx  <= '0;
          row_acc  <= '0;
        end
        ACCUM: if (accept) begin
          row_acc[bit_idx] <= row_acc[bit_idx] | PIX_DATA;
          sub_col <= sub_col_last ? '0 : sub_col + 1'b1;
          if (sub_col_last) begin
            blk_col <= blk_col_last ? '0 : blk_col + 1'b1;
            if (blk_col_last) sub_line <= sub_line_last ? '0 : sub_line + 1'b1;
          end
        end
        WRITE: begin
          row_acc <= '0;
          row_idx <= row_last ? '0 : row_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign PIX_READY     = (state == ACCUM);
  assign BUSY          = (state != IDLE);
  assign AVL_CS        = (state == WRITE);
  assign AVL_WRITE     = (state == WRITE);
  assign AVL_ADDR      = (state == WRITE) ? 5'(row_idx) : 5'd0;
  assign AVL_WRITEDATA = (state == WRITE) ? 32'(row_acc) : 32'd0;
  assign FRAME_DONE    = (state == DONE);

endmodule

// File: tb/tb_image_row_packer.sv
// Scoreboard bench for image_row_packer: expected row writes are computed from a
// reference image, queued when a frame is driven, and popped on each Avalon write.
module tb_image_row_packer;

  localparam int SCALE = 2;
  localparam int OUT   = 28;
  localparam int SRC   = SCALE * OUT;
  localparam int NPIX  = SRC * SRC;
  localparam int ROWPIX = SCALE * SRC;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FRAME_START = 1'b0;
  logic        PIX_VALID = 1'b0;
  logic        PIX_DATA = 1'b0;
  logic        PIX_READY, AVL_CS, AVL_WRITE, BUSY, FRAME_DONE;
  logic [4:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int last_wr = -1;
  int last_addr = -1;
  bit spacing_en = 1'b0;
  wr_t exp_q[$];
  bit img [0:SRC-1][0:SRC-1];

  image_row_packer #(.SCALE(SCALE), .OUT_DIM(OUT)) dut (
    .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START),
    .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_READY(PIX_READY),
    .AVL_CS(AVL_CS), .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (PIX_VALID && PIX_READY) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (AVL_WRITE) begin
        wr_t e;
        check("wr_cs", 32'(AVL_CS), 32'd1);
        check("wr_ready_low", 32'(PIX_READY), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(AVL_ADDR), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(AVL_ADDR), 32'(e.addr));
          check("wr_data", AVL_WRITEDATA, e.data);
        end
        if (spacing_en && last_wr >= 0)
          check("wr_spacing", 32'(cyc - last_wr), 32'(ROWPIX + 1));
        last_wr = cyc;
        last_addr = int'(AVL_ADDR);
        wr_cnt++;
      end else begin
        check("idle_bus", {AVL_CS, AVL_ADDR, AVL_WRITEDATA[25:0]} | 32'(|AVL_WRITEDATA), 32'd0);
      end
      if (FRAME_DONE) begin
        done_cnt++;
        check("done_after_addr27", 32'(last_addr), 32'd27);
        check("done_latency", 32'(cyc - last_wr), 32'd1);
      end
    end
  end

  task automatic clear_img(input bit v);
    for (int y = 0; y < SRC; y++)
      for (int x = 0; x < SRC; x++) img[y][x] = v;
  endtask

  task automatic push_expected(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      wr_t e;
      e.addr = 5'(r);
      e.data = '0;
      for (int c = 0; c < OUT; c++)
        for (int sy = 0; sy < SCALE; sy++)
          for (int sx = 0; sx < SCALE; sx++)
            if (img[r*SCALE+sy][c*SCALE+sx]) e.data[27-c] = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Starts a frame and drives npix pixels; fs_at re-pulses FRAME_START with that pixel.
  task automatic drive_frame(input int npix, input int gap_pct, input int fs_at);
    @(negedge CLK);
    FRAME_START = 1'b1;
    @(negedge CLK);
    FRAME_START = 1'b0;
    for (int i = 0; i < npix; i++) begin
      int  guard;
      bit  rdy;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        @(negedge CLK);
        PIX_VALID   = 1'b0;
        FRAME_START = 1'b0;
      end
      guard = 0;
      do begin
        @(negedge CLK);
        PIX_VALID   = 1'b1;
        PIX_DATA    = img[i / SRC][i % SRC];
        FRAME_START = (i == fs_at);
        rdy         = PIX_READY;
        guard++;
      end while (!rdy && guard < 3);
      if (!rdy) begin
        check("pixel_stall_timeout", 32'(i), 32'hFFFF_FFFF);
        break;
      end
    end
    @(negedge CLK);
    PIX_VALID   = 1'b0;
    FRAME_START = 1'b0;
  endtask

  // Waits for FRAME_DONE (bounded), optionally re-pulses FRAME_START in DONE.
  task automatic finish_frame(input int done_before, input bit pulse_in_done);
    int k;
    k = 0;
    while (!FRAME_DONE && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (pulse_in_done && FRAME_DONE) begin
      FRAME_START = 1'b1;
      @(negedge CLK);
      FRAME_START = 1'b0;
    end
    repeat (6) @(posedge CLK);
    check("done_once", 32'(done_cnt), 32'(done_before + 1));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("busy_low_after", 32'(BUSY), 32'd0);
  endtask

  initial begin
    int d0, a0, w0;
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(PIX_READY), 32'd0);
    check("rst_cs", 32'(AVL_CS), 32'd0);
    check("rst_write", 32'(AVL_WRITE), 32'd0);
    check("rst_addr", 32'(AVL_ADDR), 32'd0);
    check("rst_data", AVL_WRITEDATA, 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(FRAME_DONE), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // 1: all-zero frame, continuous valid, spacing checked
    clear_img(1'b0);
    push_expected(OUT);
    spacing_en = 1'b1;
    last_wr = -1;
    d0 = done_cnt;
    drive_frame(NPIX, 0, -1);
    finish_frame(d0, 1'b0);
    spacing_en = 1'b0;

    // 2: single ink at top-left, then at bottom-right
    clear_img(1'b0);
    img[0][0] = 1'b1;
    push_expected(OUT);
    d0 = done_cnt;
    drive_frame(NPIX, 0, -1);
    finish_frame(d0, 1'b0);
    clear_img(1'b0);
    img[SRC-1][SRC-1] = 1'b1;
    push_expected(OUT);
    d0 = done_cnt;
    drive_frame(NPIX, 0, -1);
    finish_frame(d0, 1'b0);

    // 3: two pixels inside block (row 1, col 1) merge into one bit
    clear_img(1'b0);
    img[SCALE][2*SCALE-1] = 1'b1;
    img[2*SCALE-1][SCALE] = 1'b1;
    push_expected(OUT);
    check("merge_model", exp_q[1].data, 32'h0400_0000);
    d0 = done_cnt;
    drive_frame(NPIX, 0, -1);
    finish_frame(d0, 1'b0);

    // 4: all-ink frame with ~30% valid gaps; accepted-pixel count must be exact
    clear_img(1'b1);
    push_expected(OUT);
    d0 = done_cnt;
    a0 = acc_cnt;
    drive_frame(NPIX, 30, -1);
    finish_frame(d0, 1'b0);
    check("accepted_total", 32'(acc_cnt - a0), 32'(NPIX));

    // 5: reset right after the addr-2 write, then a fresh random frame
    for (int y = 0; y < SRC; y++)
      for (int x = 0; x < SRC; x++) img[y][x] = ($urandom_range(0, 99) < 4);
    push_expected(3);
    w0 = wr_cnt;
    drive_frame(3 * ROWPIX, 0, -1);
    for (int k = 0; k < 20 && wr_cnt < w0 + 3; k++) @(posedge CLK);
    check("pre_reset_writes", 32'(wr_cnt - w0), 32'd3);
    @(negedge CLK);
    RESET     = 1'b1;
    PIX_VALID = 1'b1;
    PIX_DATA  = 1'b1;
    @(negedge CLK);
    check("mid_rst_bus", {26'd0, AVL_CS, AVL_WRITE, BUSY, FRAME_DONE, PIX_READY, |AVL_ADDR}, 32'd0);
    check("mid_rst_data", AVL_WRITEDATA, 32'd0);
    RESET     = 1'b0;
    PIX_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    check("no_write_after_rst", 32'(wr_cnt - w0), 32'd3);
    check("queue_after_rst", 32'(exp_q.size()), 32'd0);
    for (int y = 0; y < SRC; y++)
      for (int x = 0; x < SRC; x++) img[y][x] = ((x * 7 + y * 3) % 11 == 0);
    push_expected(OUT);
    d0 = done_cnt;
    drive_frame(NPIX, 0, -1);
    finish_frame(d0, 1'b0);

    // 6: FRAME_START mid-ACCUM and in DONE both ignored
    for (int y = 0; y < SRC; y++)
      for (int x = 0; x < SRC; x++) img[y][x] = ((x + 2 * y) % 13 == 0);
    push_expected(OUT);
    d0 = done_cnt;
    w0 = wr_cnt;
    drive_frame(NPIX, 0, 5 * ROWPIX + 17);
    finish_frame(d0, 1'b1);
    check("writes_frame6", 32'(wr_cnt - w0), 32'd28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
